// File: rtl/dcache_pkg.sv
// dcache_pkg: shared state encoding and flattened-bus helpers for the data-cache access controller
package dcache_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESPOND, DRAIN} dcache_ctrl_state_e;
  localparam int REQ_WRITE_BIT = 0;
  localparam int MAX_BUS_W = 1024;
  localparam int MAX_SLICE_W = 128;
  function automatic logic [MAX_SLICE_W-1:0] port_slice(input logic [MAX_BUS_W-1:0] bus, input int idx, input int w);
    return MAX_SLICE_W'(bus >> (idx * w));
  endfunction
endpackage

// File: rtl/dcache_access_ctrl_if.sv
// dcache_access_ctrl_if: cache/memory request-response bus between controller (master) and memory (slave)
interface dcache_access_ctrl_if #(
  parameter int PORT_WIDTH = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic mem_req_valid;
  logic mem_req_ready;
  logic mem_req_we;
  logic [PORT_WIDTH-1:0] mem_req_type;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic [DATA_WIDTH-1:0] mem_req_wdata;
  logic mem_resp_valid;
  logic [DATA_WIDTH-1:0] mem_resp_rdata;
  modport master (
    output mem_req_valid, mem_req_we, mem_req_type, mem_req_addr, mem_req_wdata,
    input mem_req_ready, mem_resp_valid, mem_resp_rdata
  );
  modport slave (
    input mem_req_valid, mem_req_we, mem_req_type, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata
  );
endinterface

// File: rtl/dcache_timeout_ctr.sv
// dcache_timeout_ctr: saturating response-wait counter, expired once it reaches TIMEOUT_CYCLES-1
module dcache_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
  logic [W-1:0] cnt;
  assign expired = cnt == LAST;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && !expired) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/dcache_access_ctrl.sv
// dcache_access_ctrl: single-outstanding cache/memory transaction engine behind the port arbiter
module dcache_access_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int PSEL_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  parameter int PORT_WIDTH = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic [NUM_PORTS-1:0] grant,
  input  logic [PSEL_W-1:0] selected_port,
  input  logic [PORT_WIDTH-1:0] selected_type,
  input  logic [NUM_PORTS-1:0] req_abort,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_wdata,
  output logic resp_done,
  output logic resp_ready,
  dcache_access_ctrl_if.master mem,
  output logic [NUM_PORTS-1:0] port_resp_valid,
  output logic [DATA_WIDTH-1:0] port_resp_rdata,
  output logic port_resp_err
);
  dcache_ctrl_state_e state, state_n;
  logic [PSEL_W-1:0] port;
  logic [PORT_WIDTH-1:0] rtype;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata, rdata;
  logic err, stale, expired, start, hs, abort, resp, tmo;
  logic [MAX_BUS_W-1:0] addr_bus, wdata_bus;
  assign addr_bus = MAX_BUS_W'(port_addr);
  assign wdata_bus = MAX_BUS_W'(port_wdata);
  assign resp = mem.mem_resp_valid;
  assign abort = req_abort[port];
  assign start = state == IDLE && |grant && !req_abort[selected_port];
  assign hs = mem.mem_req_valid && mem.mem_req_ready;
  assign tmo = state == WAIT && !resp && !abort && expired;
  assign resp_ready = state == IDLE;
  assign resp_done = state == RESPOND;
  assign port_resp_valid = resp_done ? NUM_PORTS'(1) << port : '0;
  assign port_resp_rdata = rdata;
  assign port_resp_err = err;
  // Requests stay masked until the memory has returned the response orphaned by a timeout
  assign mem.mem_req_valid = state == ISSUE && !stale;
  assign mem.mem_req_we = rtype[REQ_WRITE_BIT];
  assign mem.mem_req_type = rtype;
  assign mem.mem_req_addr = addr;
  assign mem.mem_req_wdata = wdata;
  dcache_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk(clk),
    .rst(rst),
    .clr(hs),
    .en(state == WAIT),
    .expired(expired)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? ISSUE : IDLE;
      ISSUE:   state_n = hs ? WAIT : abort ? IDLE : ISSUE;
      WAIT:    state_n = resp ? (abort ? IDLE : RESPOND) : abort ? DRAIN : expired ? RESPOND : WAIT;
      RESPOND: state_n = IDLE;
      DRAIN:   state_n = resp ? IDLE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      port <= '0;
      rtype <= '0;
      addr <= '0;
      wdata <= '0;
      rdata <= '0;
      err <= 1'b0;
      stale <= 1'b0;
    end else begin
      state <= state_n;
      stale <= tmo | (stale & !resp);
      if (start) begin
        port <= selected_port;
        rtype <= selected_type;
        addr <= ADDR_WIDTH'(port_slice(addr_bus, int'(selected_port), ADDR_WIDTH));
        wdata <= DATA_WIDTH'(port_slice(wdata_bus, int'(selected_port), DATA_WIDTH));
      end
      if (state == WAIT && resp) begin
        rdata <= rtype[REQ_WRITE_BIT] ? '0 : mem.mem_resp_rdata;
        err <= 1'b0;
      end else if (tmo) begin
        rdata <= '0;
        err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dcache_access_ctrl.sv
// tb_dcache_access_ctrl: randomized arbiter/memory environment with a cycle-level expectation model
module tb_dcache_access_ctrl;
  localparam int TMO = 8;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] grant, req_abort;
  logic [0:0] selected_port;
  logic [1:0] selected_type;
  logic [63:0] port_addr, port_wdata;
  logic resp_done, resp_ready, port_resp_err;
  logic [1:0] port_resp_valid;
  logic [31:0] port_resp_rdata;
  int checks = 0;
  int failures = 0;
  bit stale_m = 0;
  logic [31:0] mem_m [logic [31:0]];

  dcache_access_ctrl_if #(.PORT_WIDTH(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) mbus ();

  dcache_access_ctrl #(
    .NUM_PORTS(2), .PORT_WIDTH(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .grant(grant), .selected_port(selected_port),
    .selected_type(selected_type), .req_abort(req_abort), .port_addr(port_addr),
    .port_wdata(port_wdata), .resp_done(resp_done), .resp_ready(resp_ready), .mem(mbus),
    .port_resp_valid(port_resp_valid), .port_resp_rdata(port_resp_rdata),
    .port_resp_err(port_resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] lookup(input logic [31:0] a);
    return mem_m.exists(a) ? mem_m[a] : a ^ 32'hC0DE_0000;
  endfunction

  task automatic idle_inputs();
    grant = '0;
    req_abort = '0;
    mbus.mem_req_ready = 1'b0;
    mbus.mem_resp_valid = 1'b0;
  endtask

  // mode: 0 normal, 1 abort in ISSUE, 2 abort in WAIT, 3 no response (timeout)
  task automatic txn(input int p, input logic [1:0] ty, input logic [31:0] a, input logic [31:0] wd,
                     input int rdy_d, input int rsp_d, input int mode, input int late_d);
    int hs = -1, rsp_at = -1, exp_done = -1, idle_at = -1, abort_at = -1, vcnt = 0, cyc;
    int clear_at = stale_m ? late_d : 0;
    logic [31:0] cap_addr = '0, cap_wd = '0;
    logic cap_we = 1'b0;
    logic [31:0] exp_rd;
    exp_rd = ty[0] ? 32'h0 : lookup(a);
    grant = 2'(2'b01 << p);
    selected_port = 1'(p);
    selected_type = ty;
    port_addr[p*32 +: 32] = a;
    port_addr[(1-p)*32 +: 32] = $urandom;
    port_wdata[p*32 +: 32] = wd;
    port_wdata[(1-p)*32 +: 32] = $urandom;
    for (cyc = 1; cyc < 60 && (idle_at < 0 || cyc <= idle_at); cyc++) begin
      @(negedge clk);
      idle_inputs();
      if (hs < 0 && abort_at < 0) begin
        chk("req_valid", mbus.mem_req_valid, cyc > clear_at);
        if (mbus.mem_req_valid)
          chk("req_fields", {mbus.mem_req_addr, mbus.mem_req_wdata, mbus.mem_req_we, mbus.mem_req_type},
              {a, wd, ty[0], ty});
        if (stale_m && cyc == late_d) begin
          mbus.mem_resp_valid = 1'b1;
          mbus.mem_resp_rdata = $urandom;
          stale_m = 0;
        end
        if (mode == 1 && mbus.mem_req_valid && vcnt == rdy_d) begin
          req_abort[p] = 1'b1;
          abort_at = cyc;
          idle_at = cyc + 1;
        end else if (mbus.mem_req_valid && vcnt >= rdy_d) begin
          mbus.mem_req_ready = 1'b1;
          hs = cyc;
          cap_addr = mbus.mem_req_addr;
          cap_wd = mbus.mem_req_wdata;
          cap_we = mbus.mem_req_we;
          rsp_at = mode == 3 ? -1 : hs + 1 + rsp_d;
          exp_done = mode == 2 ? -1 : mode == 3 ? hs + 1 + TMO : rsp_at + 1;
          idle_at = mode == 2 ? rsp_at + 1 : exp_done + 1;
        end
        if (mbus.mem_req_valid) vcnt++;
      end else begin
        chk("req_valid_off", mbus.mem_req_valid, 0);
        if (mode == 2 && cyc == hs + 1) req_abort[p] = 1'b1;
        if (cyc == rsp_at) begin
          mbus.mem_resp_valid = 1'b1;
          mbus.mem_resp_rdata = cap_we ? $urandom : lookup(cap_addr);
          if (cap_we) mem_m[cap_addr] = cap_wd;
        end
      end
      chk("resp_done", resp_done, cyc == exp_done);
      chk("port_strobe", port_resp_valid, cyc == exp_done ? 2'(2'b01 << p) : 2'b00);
      chk("resp_ready", resp_ready, cyc == idle_at);
      if (cyc == exp_done)
        chk("resp_data", {port_resp_err, port_resp_rdata}, {mode == 3, mode == 3 ? 32'h0 : exp_rd});
    end
    chk("txn_bound", idle_at >= 0 && cyc > idle_at, 1);
    if (mode == 3) stale_m = 1;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    selected_port = '0;
    selected_type = '0;
    port_addr = '0;
    port_wdata = '0;
    mbus.mem_resp_rdata = '0;
    mem_m[32'h100] = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {resp_ready, resp_done, mbus.mem_req_valid, mbus.mem_req_we, port_resp_valid, port_resp_err},
        7'b1000000);
    chk("rst_data", {mbus.mem_req_addr, mbus.mem_req_wdata, mbus.mem_req_type}, 66'h0);
    rst = 1'b0;
    @(negedge clk);
    txn(1, 2'b00, 32'h100, 32'h0, 1, 1, 0, 0);
    txn(0, 2'b01, 32'h40, 32'h1234, 0, 0, 0, 0);
    txn(0, 2'b00, 32'h80, 32'h5, 3, 0, 1, 0);
    txn(1, 2'b10, 32'h84, 32'h6, 0, 4, 2, 0);
    txn(0, 2'b00, 32'h40, 32'h7, 0, 0, 3, 0);
    txn(1, 2'b00, 32'h40, 32'h8, 0, 1, 0, 3);
    for (int i = 0; i < 20; i++) begin
      int r = $urandom_range(0, 9);
      int m = r == 8 ? 1 : r == 9 ? 2 : 0;
      txn(i % 2, 2'($urandom), 32'h200 + {$urandom_range(0, 7), 2'b00}, $urandom,
          $urandom_range(0, 3), m == 2 ? 4 : $urandom_range(0, 3), m, 0);
    end
    // Reset in WAIT abandons the transaction; the orphaned response lands in IDLE and must be ignored
    grant = 2'b01;
    selected_port = 1'b0;
    selected_type = 2'b00;
    @(negedge clk);
    idle_inputs();
    mbus.mem_req_ready = 1'b1;
    @(negedge clk);
    idle_inputs();
    #2 rst = 1'b1;
    #1 chk("async_rst", {resp_ready, mbus.mem_req_valid, mbus.mem_req_addr}, {1'b1, 1'b0, 32'h0});
    @(negedge clk);
    rst = 1'b0;
    mbus.mem_resp_valid = 1'b1;
    mbus.mem_resp_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    idle_inputs();
    chk("ignore_resp", {resp_done, port_resp_valid, resp_ready, mbus.mem_req_valid}, 5'b00010);
    @(negedge clk);
    chk("ignore_resp2", {resp_done, resp_ready}, 2'b01);
    txn(1, 2'b00, 32'h100, 32'h0, 0, 2, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "time limit");
  end
endmodule
